comp_load_ctrl: RTL and testbench
=================================

// Module: comp_load_ctrl
// PURPOSE
//  Sequencer for the 8-bit magnitude comparator path: debounces four push buttons,
//  loads operands A and B a nibble at a time from the 4-bit switch bank y,
//  enforces the order A_lo, A_hi, B_lo, B_hi, then compares A and B and latches
//  the result on three LEDs. It sits between the board I/O and the comparator datapath.
// PARAMETERS
//  DB_CYCLES  250000  cycles a synced button level must differ before it is accepted (>=2)
//  CNT_W      18      debounce counter width; must satisfy 2**CNT_W > DB_CYCLES
// PORTS
//  clk      in   1  system clock, all state on rising edge
//  reset    in   1  synchronous, active-high reset
//  y        in   4  nibble switches, sampled directly (no debounce) when a load is accepted
//  pb1      in   1  load A[3:0], async button, active-high
//  pb2      in   1  load A[7:4]
//  pb3      in   1  load B[3:0]
//  pb4      in   1  load B[7:4]
//  a        out  8  operand A register
//  b        out  8  operand B register
//  l0       out  1  A < B  (valid only while done=1)
//  l1       out  1  A == B
//  l2       out  1  A > B
//  done     out  1  result on l0..l2 is valid
//  seq_err  out  1  one-cycle pulse on a rejected press
//  state    out  3  current FSM state, for debug LEDs
// BEHAVIOUR
//  Reset: all outputs 0; debounced levels 0; counters 0; state=W_ALO (0).
//  Button conditioning (per button, independent):
//   - 2-flop synchroniser, then debounce: a counter runs while sync != deb_level and
//     clears on any cycle they match. When the counter reaches DB_CYCLES-1 and still
//     differs, deb_level flips and the counter clears.
//   - press pulse p_i = registered (deb_level & ~deb_level_d): 1 cycle per accepted press.
//     Release produces no event. Pin-to-pulse latency = 2 + DB_CYCLES + 1 cycles.
//  FSM states (encoding): W_ALO=0, W_AHI=1, W_BLO=2, W_BHI=3, CMP=4, SHOW=5.
//   - W_ALO: p1 -> a[3:0]<=y, go W_AHI.
//   - W_AHI: p2 -> a[7:4]<=y, go W_BLO.
//   - W_BLO: p3 -> b[3:0]<=y, go W_BHI.
//   - W_BHI: p4 -> b[7:4]<=y, go CMP.
//   - CMP: lasts one cycle. Registers l0/l1/l2 from unsigned compare of a and b,
//     sets done=1, goes SHOW. Exactly one of l0..l2 is 1 whenever done=1.
//   - SHOW: holds the result. p1 -> clear done and l0..l2, a[3:0]<=y, a[7:4]<=0,
//     b<=0, go W_AHI. This restarts the sequence.
//   - Load latency: y captured on the edge ending the cycle with p_i=1.
//     The result is valid 2 cycles after that p4 cycle.
//  Rejection rules; on rejection, registers and state are unchanged and seq_err=1 next cycle:
//   - a single pulse that does not match the current state's expected button;
//   - two or more pulses in the same cycle, even if one of them is expected;
//   - any pulse during CMP.
//  done, l0..l2 are 0 in every state other than SHOW.
//  Reset mid-sequence: the next edge returns to W_ALO and clears a and b. Debouncers
//   restart from level 0, so a button held through reset yields a fresh press after DB_CYCLES.
//  Bounce shorter than DB_CYCLES cycles produces no pulse.
// TESTING (bench uses DB_CYCLES=4)
//  1) y=1 pb1, y=0 pb2, y=0 pb3, y=0 pb4, each held 10 cycles -> a=01, b=00, l2=1, done=1.
//  2) Load A=3C, B=3C -> l1=1, l0=l2=0. Then load A=05, B=F0 -> l0=1.
//  3) In W_ALO press pb3 -> seq_err pulses 1 cycle, state stays 0, b unchanged.
//     pb1 and pb2 rising in the same cycle in W_ALO -> seq_err, no load.
//  4) Toggle pb1 every 2 cycles for 20 cycles -> no pulse, state=0. Then hold 10 cycles
//     -> exactly one load. Holding pb1 for 100 cycles -> one load only.
//  5) Reach W_BHI, assert reset for 1 cycle -> state=0, a=b=0, all LEDs 0.
//     A full sequence afterwards completes normally.
//  6) In SHOW with done=1, press pb1 with y=7 -> done=0, a=07, state=W_AHI.

Source files
------------

// File: rtl/comp_load_ctrl.sv
// ---------------------------------------------------------------------------
// comp_load_ctrl
//   Operand-load sequencer for an 8-bit magnitude comparator. Four async push
//   buttons are synchronised and debounced. Each accepted press loads one
//   nibble from the switch bank y, in the order A_lo, A_hi, B_lo, B_hi. A and B
//   are then compared and the result is latched on three LEDs.
//
// Ports
//   clk            system clock; all state changes on the rising edge
//   reset          synchronous, active-high reset
//   y[3:0]         nibble switches, sampled when a load is accepted
//   pb1..pb4       async buttons: load A[3:0], A[7:4], B[3:0], B[7:4]
//   a[7:0], b[7:0] operand registers
//   l0 / l1 / l2   A<B / A==B / A>B, valid while done=1
//   done           comparison result valid
//   seq_err        one-cycle pulse after a rejected press
//   state[2:0]     current FSM state, for debug LEDs
// ---------------------------------------------------------------------------
module comp_load_ctrl #(
    parameter int DB_CYCLES = 250000,
    parameter int CNT_W     = 18
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] y,
    input  logic       pb1,
    input  logic       pb2,
    input  logic       pb3,
    input  logic       pb4,
    output logic [7:0] a,
    output logic [7:0] b,
    output logic       l0,
    output logic       l1,
    output logic       l2,
    output logic       done,
    output logic       seq_err,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        W_ALO = 3'd0,
        W_AHI = 3'd1,
        W_BLO = 3'd2,
        W_BHI = 3'd3,
        CMP   = 3'd4,
        SHOW  = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [3:0] pb_raw;
    logic [3:0] press;

    assign pb_raw = {pb4, pb3, pb2, pb1};

    // Per-button conditioning: 2-flop synchroniser, counter debounce, and a
    // registered rising-edge detect on the debounced level.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_btn
            logic             sync1_reg;
            logic             sync2_reg;
            logic             deb_reg;
            logic             deb_d_reg;
            logic             press_reg;
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    deb_reg   <= 1'b0;
                    deb_d_reg <= 1'b0;
                    press_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= pb_raw[gi];
                    sync2_reg <= sync1_reg;
                    deb_d_reg <= deb_reg;
                    press_reg <= deb_reg & ~deb_d_reg;
                    // Any cycle of agreement restarts the count, so only an
                    // uninterrupted run of DB_CYCLES disagreeing samples flips.
                    if (sync2_reg == deb_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        deb_reg <= ~deb_reg;
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end
            end

            assign press[gi] = press_reg;
        end
    endgenerate

    // Sequencer
    state_t     state_reg, state_next;
    logic [7:0] a_reg, a_next;
    logic [7:0] b_reg, b_next;
    logic [2:0] led_reg, led_next;     // {l2, l1, l0}
    logic       done_reg, done_next;
    logic       err_reg, err_next;
    logic [3:0] expected;
    logic       single_press;
    logic       accept;

    // One-hot mask of the button the current state is waiting for; CMP waits
    // for nothing, so every press there is rejected.
    always_comb begin
        expected = 4'b0000;
        case (state_reg)
            W_ALO:   expected = 4'b0001;
            W_AHI:   expected = 4'b0010;
            W_BLO:   expected = 4'b0100;
            W_BHI:   expected = 4'b1000;
            SHOW:    expected = 4'b0001;
            default: expected = 4'b0000;
        endcase
    end

    // Exactly one pulse set: clearing the lowest set bit leaves nothing.
    assign single_press = (press != 4'd0) && ((press & (press - 4'd1)) == 4'd0);
    assign accept       = single_press && (press == expected);

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        led_next   = led_reg;
        done_next  = done_reg;
        err_next   = (press != 4'd0) && !accept;

        case (state_reg)
            W_ALO: if (accept) begin
                a_next[3:0] = y;
                state_next  = W_AHI;
            end
            W_AHI: if (accept) begin
                a_next[7:4] = y;
                state_next  = W_BLO;
            end
            W_BLO: if (accept) begin
                b_next[3:0] = y;
                state_next  = W_BHI;
            end
            W_BHI: if (accept) begin
                b_next[7:4] = y;
                state_next  = CMP;
            end
            // Single-cycle compare; a stray press here is flagged but does not
            // stall the comparison.
            CMP: begin
                led_next   = {(a_reg > b_reg), (a_reg == b_reg), (a_reg < b_reg)};
                done_next  = 1'b1;
                state_next = SHOW;
            end
            // pb1 in SHOW restarts the sequence and doubles as the A_lo load.
            SHOW: if (accept) begin
                a_next     = {4'h0, y};
                b_next     = 8'h00;
                led_next   = 3'b000;
                done_next  = 1'b0;
                state_next = W_AHI;
            end
            default: begin
                led_next   = 3'b000;
                done_next  = 1'b0;
                state_next = W_ALO;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= W_ALO;
            a_reg     <= 8'h00;
            b_reg     <= 8'h00;
            led_reg   <= 3'b000;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            led_reg   <= led_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
        end
    end

    assign a            = a_reg;
    assign b            = b_reg;
    assign {l2, l1, l0} = led_reg;
    assign done         = done_reg;
    assign seq_err      = err_reg;
    assign state        = state_reg;

endmodule

// File: tb/tb_comp_load_ctrl.sv
// ---------------------------------------------------------------------------
// tb_comp_load_ctrl
//   Self-checking bench for comp_load_ctrl with DB_CYCLES=4. Directed
//   scenarios are followed by randomised button activity. Every cycle the DUT
//   outputs are compared with a behavioural model. The model expresses the
//   debounce as "the last DB synchronised samples all disagree with the
//   current level". It expresses the sequencer as a table of expected buttons.
// ---------------------------------------------------------------------------
module tb_comp_load_ctrl;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] y;
    logic       pb1, pb2, pb3, pb4;
    logic [7:0] a, b;
    logic       l0, l1, l2, done, seq_err;
    logic [2:0] state;

    int n_tests = 0;
    int n_fail  = 0;
    int err_seen = 0;

    always #5 clk = ~clk;

    comp_load_ctrl #(.DB_CYCLES(DB), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .y(y),
        .pb1(pb1), .pb2(pb2), .pb3(pb3), .pb4(pb4),
        .a(a), .b(b), .l0(l0), .l1(l1), .l2(l2),
        .done(done), .seq_err(seq_err), .state(state)
    );

    // ---------------- reference model ----------------
    int           m_state;
    logic [7:0]   m_a, m_b;
    logic [2:0]   m_led;              // {l2, l1, l0}
    logic         m_done, m_err;
    logic [DB+1:0] hist [4];          // hist[i][0] = pin at the latest edge
    logic         m_level [4];
    logic         m_rose  [4];
    logic         m_pulse [4];

    task automatic model_clear();
        m_state = 0; m_a = 8'h00; m_b = 8'h00; m_led = 3'b000;
        m_done = 1'b0; m_err = 1'b0;
        for (int i = 0; i < 4; i++) begin
            hist[i] = '0; m_level[i] = 1'b0; m_rose[i] = 1'b0; m_pulse[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        logic [3:0] pins;
        logic [3:0] p;
        int         want;
        logic       ok;
        logic       rose_new;
        if (reset) begin
            model_clear();
            return;
        end
        pins = {pb4, pb3, pb2, pb1};
        p    = {m_pulse[3], m_pulse[2], m_pulse[1], m_pulse[0]};
        case (m_state)
            0: want = 0;
            1: want = 1;
            2: want = 2;
            3: want = 3;
            5: want = 0;
            default: want = -1;
        endcase
        ok = 1'b0;
        if ($countones(p) == 1 && want >= 0) ok = p[want];
        m_err = ($countones(p) > 0) && !ok;
        case (m_state)
            0: if (ok) begin m_a[3:0] = y; m_state = 1; end
            1: if (ok) begin m_a[7:4] = y; m_state = 2; end
            2: if (ok) begin m_b[3:0] = y; m_state = 3; end
            3: if (ok) begin m_b[7:4] = y; m_state = 4; end
            4: begin
                if (m_a < m_b)       m_led = 3'b001;
                else if (m_a == m_b) m_led = 3'b010;
                else                 m_led = 3'b100;
                m_done  = 1'b1;
                m_state = 5;
            end
            5: if (ok) begin
                m_a = {4'h0, y}; m_b = 8'h00; m_led = 3'b000; m_done = 1'b0; m_state = 1;
            end
            default: m_state = 0;
        endcase
        for (int i = 0; i < 4; i++) begin
            hist[i]  = {hist[i][DB:0], pins[i]};
            rose_new = 1'b0;
            // Samples seen by the debouncer lag the pin by two edges.
            if (hist[i][DB+1:2] == {DB{~m_level[i]}}) begin
                m_level[i] = ~m_level[i];
                rose_new   = m_level[i];
            end
            m_pulse[i] = m_rose[i];
            m_rose[i]  = rose_new;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        if (seq_err === 1'b1) err_seen++;
        check_val("state",   {29'd0, state}, m_state);
        check_val("a",       {24'd0, a}, {24'd0, m_a});
        check_val("b",       {24'd0, b}, {24'd0, m_b});
        check_val("leds",    {29'd0, l2, l1, l0}, {29'd0, m_led});
        check_val("done",    {31'd0, done}, {31'd0, m_done});
        check_val("seq_err", {31'd0, seq_err}, {31'd0, m_err});
        if (done === 1'b1) check_val("onehot", $countones({l2, l1, l0}), 1);
    endtask

    task automatic set_pin(input int btn, input logic v);
        case (btn)
            1: pb1 = v;
            2: pb2 = v;
            3: pb3 = v;
            default: pb4 = v;
        endcase
    endtask

    task automatic press(input int btn, input logic [3:0] yv, input int hold);
        y = yv;
        set_pin(btn, 1'b1);
        repeat (hold) step();
        set_pin(btn, 1'b0);
        repeat (10) step();
    endtask

    task automatic load_all(input logic [7:0] av, input logic [7:0] bv);
        press(1, av[3:0], 10);
        press(2, av[7:4], 10);
        press(3, bv[3:0], 10);
        press(4, bv[7:4], 10);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        int btn, btn2, hold, gap;
        reset = 1'b1; y = 4'h0; pb1 = 1'b0; pb2 = 1'b0; pb3 = 1'b0; pb4 = 1'b0;
        model_clear();
        step(); step();
        reset = 1'b0;
        check_val("rst_state", {29'd0, state}, 0);
        check_val("rst_ab", {16'd0, a, b}, 0);
        check_val("rst_led", {28'd0, done, l2, l1, l0}, 0);

        // 1) a=01 b=00 -> A>B
        load_all(8'h01, 8'h00);
        check_val("s1_a", {24'd0, a}, 32'h01);
        check_val("s1_b", {24'd0, b}, 32'h00);
        check_val("s1_led", {29'd0, l2, l1, l0}, 32'b100);
        check_val("s1_done", {31'd0, done}, 1);

        // 2) equal, then less-than (each restarts from SHOW)
        load_all(8'h3C, 8'h3C);
        check_val("s2_eq", {29'd0, l2, l1, l0}, 32'b010);
        load_all(8'h05, 8'hF0);
        check_val("s2_lt", {29'd0, l2, l1, l0}, 32'b001);
        check_val("s2_a", {24'd0, a}, 32'h05);

        // 3) wrong button and double press in W_ALO
        do_reset();
        err_seen = 0;
        press(3, 4'h9, 10);
        check_val("s3_err1", err_seen, 1);
        check_val("s3_state", {29'd0, state}, 0);
        check_val("s3_b", {24'd0, b}, 0);
        y = 4'hA; pb1 = 1'b1; pb2 = 1'b1;
        repeat (10) step();
        pb1 = 1'b0; pb2 = 1'b0;
        repeat (10) step();
        check_val("s3_err2", err_seen, 2);
        check_val("s3_a", {24'd0, a}, 0);

        // 4) bounce rejected, then one clean press; long hold loads once
        err_seen = 0;
        for (int i = 0; i < 10; i++) begin
            pb1 = ~pb1;
            step(); step();
        end
        repeat (10) step();
        check_val("s4_bounce", {29'd0, state}, 0);
        press(1, 4'h9, 10);
        check_val("s4_state", {29'd0, state}, 1);
        check_val("s4_a", {24'd0, a}, 32'h09);
        do_reset();
        press(1, 4'h6, 100);
        check_val("s4_hold", {29'd0, state}, 1);
        check_val("s4_noerr", err_seen, 0);

        // 5) reset while waiting for B_hi
        press(2, 4'h2, 10);
        press(3, 4'h8, 10);
        check_val("s5_bhi", {29'd0, state}, 3);
        do_reset();
        check_val("s5_state", {29'd0, state}, 0);
        check_val("s5_ab", {16'd0, a, b}, 0);
        check_val("s5_led", {28'd0, done, l2, l1, l0}, 0);
        load_all(8'hA5, 8'h5A);
        check_val("s5_gt", {29'd0, l2, l1, l0}, 32'b100);

        // 6) restart from SHOW
        press(1, 4'h7, 10);
        check_val("s6_done", {31'd0, done}, 0);
        check_val("s6_a", {24'd0, a}, 32'h07);
        check_val("s6_state", {29'd0, state}, 1);

        // Randomised activity, biased toward the expected button
        for (int s = 0; s < 300; s++) begin
            if ($urandom_range(0, 40) == 0) do_reset();
            case (m_state)
                1: btn = 2;
                2: btn = 3;
                3: btn = 4;
                default: btn = 1;
            endcase
            if ($urandom_range(0, 3) == 0) btn = $urandom_range(1, 4);
            hold = $urandom_range(1, 12);
            gap  = $urandom_range(1, 12);
            set_pin(btn, 1'b1);
            if ($urandom_range(0, 9) == 0) begin
                btn2 = $urandom_range(1, 4);
                set_pin(btn2, 1'b1);
            end
            for (int c = 0; c < hold; c++) begin
                y = 4'($urandom);
                step();
            end
            pb1 = 1'b0; pb2 = 1'b0; pb3 = 1'b0; pb4 = 1'b0;
            for (int c = 0; c < gap; c++) begin
                y = 4'($urandom);
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
